// File: rtl/src_operand_fetch.sv
// MSP430 execution-stage source operand sequencer: resolves every As mode into a
// single 16-bit operand, issuing register-file selects and memory reads as needed.
module src_operand_fetch (
    input  logic        mclk,
    input  logic        puc_n,
    input  logic        start,
    input  logic [3:0]  src_reg,
    input  logic [1:0]  as_mode,
    input  logic        inst_bw,
    input  logic [15:0] pc,
    input  logic [15:0] reg_src,
    input  logic [15:0] mdb_in,
    output logic        busy,
    output logic [15:0] inst_src,
    output logic        reg_incr,
    output logic        pc_incr,
    output logic        mb_en,
    output logic [15:0] mab,
    output logic [15:0] op_src,
    output logic        op_valid
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REG      = 3'd1;
    localparam logic [2:0] S_EXT      = 3'd2;
    localparam logic [2:0] S_EXT_WAIT = 3'd3;
    localparam logic [2:0] S_RD       = 3'd4;
    localparam logic [2:0] S_RD_WAIT  = 3'd5;

    logic [2:0]  state_reg, state_next;
    logic [3:0]  sreg_reg;
    logic [1:0]  as_reg;
    logic        bw_reg;
    logic [15:0] inst_src_reg;
    logic [15:0] ext_addr_reg;
    logic [15:0] addr_reg;
    logic [15:0] rd_addr_reg;
    logic [15:0] op_hold_reg;

    logic [15:0] src_onehot;
    logic        in_const, in_nosel;
    logic        l_const, l_imm, l_idx;
    logic [15:0] const_val, reg_val, raw_addr, base_addr, op_value;
    logic        force_even;
    logic [7:0]  mem_byte;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_onehot
            assign src_onehot[gi] = (src_reg == gi[3:0]);
        end
    endgenerate

    // Decodes on the incoming request (only meaningful while start is sampled in IDLE)
    assign in_const = (src_reg == 4'd3) || ((src_reg == 4'd2) && as_mode[1]);
    assign in_nosel = in_const || ((src_reg == 4'd2) && (as_mode == 2'b01));

    // Decodes on the latched request
    assign l_const = (sreg_reg == 4'd3) || ((sreg_reg == 4'd2) && as_reg[1]);
    assign l_imm   = (sreg_reg == 4'd0) && (as_reg == 2'b11);
    assign l_idx   = (as_reg == 2'b01) && !l_const;

    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE: begin
                state_next = S_IDLE;
                if (start) begin
                    if (in_const || (as_mode == 2'b00))
                        state_next = S_REG;
                    else if (as_mode == 2'b01)
                        state_next = S_EXT;
                    else
                        state_next = S_RD;
                end
            end
            S_REG:      state_next = S_IDLE;
            S_EXT:      state_next = S_EXT_WAIT;
            S_EXT_WAIT: state_next = S_RD;
            S_RD:       state_next = S_RD_WAIT;
            S_RD_WAIT:  state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        const_val = 16'h0000;
        if (sreg_reg == 4'd2) begin
            const_val = as_reg[0] ? 16'h0008 : 16'h0004;
        end else begin
            case (as_reg)
                2'b00:   const_val = 16'h0000;
                2'b01:   const_val = 16'h0001;
                2'b10:   const_val = 16'h0002;
                default: const_val = 16'hFFFF;
            endcase
        end
    end

    assign reg_val = l_const ? const_val : reg_src;

    // Symbolic mode indexes from the extension-word address, absolute from zero
    always_comb begin
        base_addr = reg_src;
        if (sreg_reg == 4'd0)
            base_addr = ext_addr_reg;
        else if (sreg_reg == 4'd2)
            base_addr = 16'h0000;
    end

    always_comb begin
        raw_addr = 16'h0000;
        if (state_reg == S_EXT)
            raw_addr = pc;
        else if (state_reg == S_RD) begin
            if (l_imm)
                raw_addr = pc;
            else if (l_idx)
                raw_addr = addr_reg;
            else
                raw_addr = reg_src;
        end
    end

    // Extension and immediate words are always whole words
    assign force_even = !bw_reg || (state_reg == S_EXT) || l_imm;

    assign busy     = (state_reg != S_IDLE);
    assign inst_src = inst_src_reg;
    assign mb_en    = (state_reg == S_EXT) || (state_reg == S_RD);
    assign mab      = mb_en ? {raw_addr[15:1], raw_addr[0] & !force_even} : 16'h0000;
    assign reg_incr = (state_reg == S_RD) && (as_reg == 2'b11) && !l_imm;
    assign pc_incr  = (state_reg == S_EXT) || ((state_reg == S_RD) && l_imm);
    assign op_valid = (state_reg == S_REG) || (state_reg == S_RD_WAIT);

    assign mem_byte = rd_addr_reg[0] ? mdb_in[15:8] : mdb_in[7:0];

    always_comb begin
        op_value = 16'h0000;
        if (state_reg == S_REG)
            op_value = bw_reg ? {8'h00, reg_val[7:0]} : reg_val;
        else if (state_reg == S_RD_WAIT)
            op_value = bw_reg ? {8'h00, mem_byte} : mdb_in;
    end

    assign op_src = op_valid ? op_value : op_hold_reg;

    always_ff @(posedge mclk or negedge puc_n) begin
        if (!puc_n) begin
            state_reg    <= S_IDLE;
            sreg_reg     <= 4'd0;
            as_reg       <= 2'b00;
            bw_reg       <= 1'b0;
            inst_src_reg <= 16'h0000;
            ext_addr_reg <= 16'h0000;
            addr_reg     <= 16'h0000;
            rd_addr_reg  <= 16'h0000;
            op_hold_reg  <= 16'h0000;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_IDLE) && start) begin
                sreg_reg     <= src_reg;
                as_reg       <= as_mode;
                bw_reg       <= inst_bw;
                inst_src_reg <= in_nosel ? 16'h0000 : src_onehot;
            end
            if (op_valid) begin
                inst_src_reg <= 16'h0000;
                op_hold_reg  <= op_value;
            end
            if (state_reg == S_EXT)
                ext_addr_reg <= pc;
            if (state_reg == S_EXT_WAIT)
                addr_reg <= base_addr + mdb_in;
            if (state_reg == S_RD)
                rd_addr_reg <= mab;
        end
    end

endmodule

// File: tb/tb_src_operand_fetch.sv
// Self-checking bench for src_operand_fetch: register-file and memory models plus
// an expected-operand queue checked on every op_valid pulse.
module tb_src_operand_fetch;

    logic        mclk = 1'b0;
    logic        puc_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  src_reg = 4'd0;
    logic [1:0]  as_mode = 2'b00;
    logic        inst_bw = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [15:0] reg_src;
    logic [15:0] mdb_in = 16'h0000;
    logic        busy, reg_incr, pc_incr, mb_en, op_valid;
    logic [15:0] inst_src, mab, op_src;

    logic [15:0] regs [16];
    logic [15:0] mem  [32768];
    logic [15:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    src_operand_fetch dut (
        .mclk(mclk), .puc_n(puc_n), .start(start), .src_reg(src_reg),
        .as_mode(as_mode), .inst_bw(inst_bw), .pc(pc), .reg_src(reg_src),
        .mdb_in(mdb_in), .busy(busy), .inst_src(inst_src), .reg_incr(reg_incr),
        .pc_incr(pc_incr), .mb_en(mb_en), .mab(mab), .op_src(op_src),
        .op_valid(op_valid)
    );

    always #5 mclk = ~mclk;

    // Unselected register file returns a poison value so a wrong base shows up
    always_comb begin
        reg_src = 16'hDEAD;
        for (int i = 0; i < 16; i++)
            if (inst_src == (16'h0001 << i)) reg_src = regs[i];
    end

    always @(posedge mclk)
        if (mb_en) mdb_in <= mem[mab[15:1]];

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge mclk) begin
        if (puc_n && op_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_op_valid", 16'd1, 16'd0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("op_src", op_src, e);
                $display("txn op_src=%h expected=%h", op_src, e);
            end
        end
        if (puc_n && !busy)
            chk("idle_pulses", {13'd0, mb_en, reg_incr, pc_incr}, 16'd0);
    end

    // Issues start for one cycle; returns at the negedge of the first cycle after start
    task automatic fetch(input logic [3:0] s, input logic [1:0] a, input logic b,
                         input logic [15:0] e);
        @(negedge mclk);
        start = 1'b1; src_reg = s; as_mode = a; inst_bw = b;
        exp_q.push_back(e);
        @(negedge mclk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        regs[5] = 16'h1234; regs[6] = 16'h0201; regs[4] = 16'hFFF0; regs[7] = 16'h0301;
        mem[16'h0200 >> 1] = 16'hABCD;
        mem[16'hF000 >> 1] = 16'h0020;
        mem[16'h0010 >> 1] = 16'h5A5A;
        mem[16'hC010 >> 1] = 16'h8001;
        mem[16'h4000 >> 1] = 16'h0100;
        mem[16'h4100 >> 1] = 16'h7777;
        mem[16'h4002 >> 1] = 16'h0300;
        mem[16'h0300 >> 1] = 16'h1357;

        #12;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_outs", {12'd0, mb_en, reg_incr, pc_incr, op_valid}, 16'd0);
        chk("rst_op_src", op_src, 16'h0000);
        chk("rst_inst_src", inst_src, 16'h0000);
        @(negedge mclk); puc_n = 1'b1;

        // Register mode
        fetch(4'd5, 2'b00, 1'b0, 16'h1234);
        chk("reg_inst_src", inst_src, 16'h0020);
        chk("reg_valid", {15'd0, op_valid}, 16'd1);
        chk("reg_mb_en", {15'd0, mb_en}, 16'd0);
        @(negedge mclk);
        chk("reg_busy_after", {15'd0, busy}, 16'd0);
        chk("reg_inst_src_clr", inst_src, 16'h0000);
        chk("reg_op_hold", op_src, 16'h1234);

        // Byte autoincrement from an odd address
        fetch(4'd6, 2'b11, 1'b1, 16'h00AB);
        chk("ai_mab", mab, 16'h0201);
        chk("ai_pulses", {14'd0, mb_en, reg_incr}, 16'd3);
        @(negedge mclk);
        chk("ai_valid", {15'd0, op_valid}, 16'd1);
        chk("ai_incr_single", {15'd0, reg_incr}, 16'd0);

        // Indexed with address wrap
        pc = 16'hF000;
        fetch(4'd4, 2'b01, 1'b0, 16'h5A5A);
        chk("idx_mab_ext", mab, 16'hF000);
        chk("idx_pc_incr", {15'd0, pc_incr}, 16'd1);
        @(negedge mclk);
        chk("idx_wait_mb_en", {15'd0, mb_en}, 16'd0);
        @(negedge mclk);
        chk("idx_mab_rd", mab, 16'h0010);
        chk("idx_rd_pcincr", {14'd0, pc_incr, reg_incr}, 16'd0);
        @(negedge mclk);
        chk("idx_valid", {15'd0, op_valid}, 16'd1);

        // Constant generators
        fetch(4'd3, 2'b11, 1'b1, 16'h00FF);
        chk("cg_inst_src", inst_src, 16'h0000);
        chk("cg_valid", {14'd0, op_valid, mb_en}, 16'd2);
        fetch(4'd2, 2'b10, 1'b0, 16'h0004);
        fetch(4'd2, 2'b11, 1'b0, 16'h0008);
        fetch(4'd3, 2'b01, 1'b0, 16'h0001);
        fetch(4'd3, 2'b00, 1'b0, 16'h0000);
        fetch(4'd3, 2'b11, 1'b0, 16'hFFFF);

        // Immediate, with a second start that must be ignored
        pc = 16'hC010;
        fetch(4'd0, 2'b11, 1'b0, 16'h8001);
        chk("imm_mab", mab, 16'hC010);
        chk("imm_pulses", {14'd0, pc_incr, reg_incr}, 16'd2);
        start = 1'b1; src_reg = 4'd5; as_mode = 2'b00;
        @(negedge mclk);
        start = 1'b0;
        chk("imm_valid", {15'd0, op_valid}, 16'd1);
        @(negedge mclk);
        chk("imm_second_ignored", {15'd0, busy}, 16'd0);

        // Word indirect forces an even address; absolute and symbolic indexing
        fetch(4'd7, 2'b10, 1'b0, 16'h1357);
        chk("ind_mab_even", mab, 16'h0300);
        chk("ind_no_incr", {15'd0, reg_incr}, 16'd0);
        @(negedge mclk);
        pc = 16'h4002;
        fetch(4'd2, 2'b01, 1'b0, 16'h1357);
        chk("abs_inst_src", inst_src, 16'h0000);
        repeat (3) @(negedge mclk);
        pc = 16'h4000;
        fetch(4'd0, 2'b01, 1'b1, 16'h0077);
        repeat (3) @(negedge mclk);

        // Reset in the middle of an indexed fetch
        fetch(4'd0, 2'b01, 1'b0, 16'h7777);
        @(negedge mclk);
        @(negedge mclk);
        chk("abort_in_rd", {15'd0, mb_en}, 16'd1);
        puc_n = 1'b0;
        #1;
        chk("abort_outs", {11'd0, busy, mb_en, reg_incr, pc_incr, op_valid}, 16'd0);
        chk("abort_mab", mab, 16'h0000);
        exp_q.delete();
        @(negedge mclk);
        puc_n = 1'b1;
        repeat (4) @(negedge mclk);
        chk("abort_quiet", {15'd0, busy}, 16'd0);
        fetch(4'd5, 2'b00, 1'b0, 16'h1234);
        chk("post_abort_valid", {15'd0, op_valid}, 16'd1);
        @(negedge mclk);

        chk("sb_empty", exp_q.size(), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
